sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO for buffering data between producer and consumer logic running in the same clock domain. Generalises our FIFO family in width, depth and read mode: adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, a synchronous flush and an optional first-word-fall-through (FWFT) read mode.

---
 rtl/sync_fifo_param.sv | 122 ++++++++++++
 tb/tb_sync_fifo_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, error pulses,
// synchronous flush and optional first-word-fall-through read mode.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   write,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   read,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_en, rd_en;

    // Acceptance uses the registered flags, so a read at full never frees room for a same-cycle write.
    always_comb begin
        wr_en    = write & ~full_q & ~flush;
        rd_en    = read & ~empty_q & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dout_d   = mem_q[rd_ptr_q];
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + CW'(1);
            end else if (rd_en && !wr_en) begin
                count_d = count_q - CW'(1);
            end
            ovf_d = write & full_q;
            unf_d = read & empty_q;
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_LEVEL));
        ae_d    = (count_d <= CW'(AE_LEVEL));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_comb begin
        data_out = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param: one registered-read and one FWFT
// instance share stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int W = 8;
    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, flush, write, read;
    logic [W-1:0] data_in;

    logic [W-1:0] dout0, dout1;
    logic         full0, empty0, af0, ae0, ovf0, unf0;
    logic         full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0]   cnt0, cnt1;

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_dut_reg (
        .clk(clk), .reset_n(reset_n), .flush(flush), .write(write), .data_in(data_in),
        .read(read), .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_dut_fwft (
        .clk(clk), .reset_n(reset_n), .flush(flush), .write(write), .data_in(data_in),
        .read(read), .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue contents, last registered read word, pending error pulses.
    logic [W-1:0] q[$];
    logic [W-1:0] exp_dout;
    logic         exp_ovf, exp_unf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check_eq({tag, ".count"}, 32'(cnt0), 32'(n));
        check_eq({tag, ".full"}, 32'(full0), 32'(n == D));
        check_eq({tag, ".empty"}, 32'(empty0), 32'(n == 0));
        check_eq({tag, ".af"}, 32'(af0), 32'(n >= D - 2));
        check_eq({tag, ".ae"}, 32'(ae0), 32'(n <= 2));
        check_eq({tag, ".ovf"}, 32'(ovf0), 32'(exp_ovf));
        check_eq({tag, ".unf"}, 32'(unf0), 32'(exp_unf));
        check_eq({tag, ".dout"}, 32'(dout0), 32'(exp_dout));
        check_eq({tag, ".f.count"}, 32'(cnt1), 32'(n));
        check_eq({tag, ".f.flags"}, {26'd0, full1, empty1, af1, ae1, ovf1, unf1},
                 {26'd0, n == D, n == 0, n >= D - 2, n <= 2, exp_ovf, exp_unf});
        if (n > 0) check_eq({tag, ".f.head"}, 32'(dout1), 32'(q[0]));
    endtask

    task automatic step(input string tag, input logic w, input logic [W-1:0] din,
                        input logic r, input logic fl);
        int pre;
        write   = w;
        data_in = din;
        read    = r;
        flush   = fl;
        @(posedge clk);
        pre = q.size();
        if (fl) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = w && (pre == D);
            exp_unf = r && (pre == 0);
            if (r && pre > 0) exp_dout = q.pop_front();
            if (w && pre < D) q.push_back(din);
        end
        #1;
        write = 1'b0;
        read  = 1'b0;
        flush = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        write = 1'b0; read = 1'b0; flush = 1'b0; data_in = '0;
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        reset_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] words[$];
        logic [W-1:0] v;
        reset_n = 1'b1;
        write = 1'b0; read = 1'b0; flush = 1'b0; data_in = '0;
        exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;

        do_reset();
        step("basic.w", 1'b1, 8'hA1, 1'b0, 1'b0);
        step("basic.w", 1'b1, 8'hB2, 1'b0, 1'b0);
        step("basic.w", 1'b1, 8'hC3, 1'b0, 1'b0);
        step("basic.w", 1'b1, 8'hD4, 1'b0, 1'b0);
        step("basic.r1", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("basic.first", 32'(dout0), 32'h0A1);
        step("basic.r2", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("basic.second", 32'(dout0), 32'h0B2);
        check_eq("basic.cnt2", 32'(cnt0), 32'd2);
        repeat (2) step("basic.drain", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < D; i++) step("fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
        check_eq("fill.full", 32'(full0), 32'd1);
        step("fill.extra", 1'b1, 8'h55, 1'b0, 1'b0);
        check_eq("fill.ovf", 32'(ovf0), 32'd1);
        check_eq("fill.cnt16", 32'(cnt0), 32'd16);
        for (int i = 0; i < D; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < D; i++) step("fill2", 1'b1, 8'($urandom), 1'b0, 1'b0);
        step("full.rw", 1'b1, 8'h77, 1'b1, 1'b0);
        check_eq("full.rw.cnt", 32'(cnt0), 32'd15);
        for (int i = 0; i < D - 1; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        step("empty.rw", 1'b1, 8'h3C, 1'b1, 1'b0);
        check_eq("empty.rw.unf", 32'(unf0), 32'd1);
        for (int i = 0; i < 4; i++) step("to5", 1'b1, 8'($urandom), 1'b0, 1'b0);
        step("five.rw", 1'b1, 8'h5A, 1'b1, 1'b0);
        check_eq("five.rw.cnt", 32'(cnt0), 32'd5);
        for (int i = 0; i < 5; i++) step("drain3", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) begin
            words.delete();
            for (int i = 0; i < 10; i++) begin
                v = 8'($urandom);
                words.push_back(v);
                step("wrap.w", 1'b1, v, 1'b0, 1'b0);
            end
            for (int i = 0; i < 10; i++) begin
                step("wrap.r", 1'b0, 8'h00, 1'b1, 1'b0);
                check_eq("wrap.order", 32'(dout0), 32'(words[i]));
            end
        end
        check_eq("wrap.empty", 32'(empty0), 32'd1);

        for (int i = 0; i < 7; i++) step("pre_flush", 1'b1, 8'($urandom), 1'b0, 1'b0);
        step("flush", 1'b1, 8'h99, 1'b0, 1'b1);
        check_eq("flush.cnt", 32'(cnt0), 32'd0);
        step("flush.w", 1'b1, 8'hE5, 1'b0, 1'b0);
        step("flush.r", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("flush.e5", 32'(dout0), 32'h0E5);

        step("fwft.w", 1'b1, 8'hF6, 1'b0, 1'b0);
        check_eq("fwft.f6", 32'(dout1), 32'h0F6);
        step("fwft.w2", 1'b1, 8'h07, 1'b0, 1'b0);
        step("fwft.r", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("fwft.07", 32'(dout1), 32'h007);

        for (int i = 0; i < 600; i++) begin
            logic w, r, fl;
            if (i == 300) do_reset();
            if ((i / 100) % 2 == 0) begin
                w = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 9) < 3);
            end else begin
                w = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 7);
            end
            fl = ($urandom_range(0, 49) == 0);
            step("rand", w, 8'($urandom), r, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
